// File: rtl/spi_reg_writer.sv
// SPI mode-0 initiator that serialises register-write requests into 16-bit {rw, addr, data} frames.
// Define SPI_READ_EN to enable read frames, with response data captured from cipo.
module spi_reg_writer #(
    parameter int unsigned CLK_DIV = 4,
    parameter int unsigned CS_GAP  = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic       req_write,
    input  logic [6:0] req_addr,
    input  logic [7:0] req_data,
    output logic       done,
    output logic [7:0] rsp_data,
    output logic       sclk,
    output logic       copi,
    output logic       ncs,
    input  logic       cipo
);

    localparam int unsigned DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int unsigned GW = $clog2(CS_GAP + 1);
    localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
    localparam logic [GW-1:0] GAP_LAST = GW'(CS_GAP - 1);

    typedef enum logic [2:0] {
        StIdle,
        StSetup,
        StShift,
        StHold,
        StGap
    } state_e;

    state_e        state_q;
    logic [DW-1:0] div_q;
    logic [4:0]    bit_q;
    logic [GW-1:0] gap_q;
    logic [15:0]   shift_q;
    logic          ncs_q;
    logic          sclk_q;
    logic          copi_q;
    logic          ready_q;
    logic          done_q;
    logic [15:0]   frame;

`ifdef SPI_READ_EN
    logic       rd_q;
    logic [7:0] rx_q;
    logic [7:0] rsp_q;

    // Reads carry no payload; the data byte slot is where the peripheral answers.
    assign frame    = {req_write, req_addr, req_write ? req_data : 8'h00};
    assign rsp_data = rsp_q;
`else
    logic _unused;

    assign frame    = {1'b1, req_addr, req_data};
    assign rsp_data = 8'h00;
    assign _unused  = ^{cipo, req_write};
`endif

    assign req_ready = ready_q;
    assign done      = done_q;
    assign sclk      = sclk_q;
    assign copi      = copi_q;
    assign ncs       = ncs_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            div_q   <= '0;
            bit_q   <= '0;
            gap_q   <= '0;
            shift_q <= '0;
            ncs_q   <= 1'b1;
            sclk_q  <= 1'b0;
            copi_q  <= 1'b0;
            ready_q <= 1'b1;
            done_q  <= 1'b0;
`ifdef SPI_READ_EN
            rd_q    <= 1'b0;
            rx_q    <= '0;
            rsp_q   <= '0;
`endif
        end else begin
            done_q <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (req_valid) begin
                        shift_q <= frame;
                        copi_q  <= frame[15];
                        ncs_q   <= 1'b0;
                        sclk_q  <= 1'b0;
                        ready_q <= 1'b0;
                        div_q   <= '0;
                        bit_q   <= '0;
`ifdef SPI_READ_EN
                        rd_q    <= ~req_write;
`endif
                        state_q <= StSetup;
                    end
                end
                StSetup: begin
                    if (div_q == DIV_LAST) begin
                        div_q   <= '0;
                        sclk_q  <= 1'b1;
                        state_q <= StShift;
                    end else begin
                        div_q <= div_q + DW'(1);
                    end
                end
                StShift: begin
                    if (div_q == DIV_LAST) begin
                        div_q <= '0;
                        if (sclk_q) begin
                            sclk_q <= 1'b0;
                            bit_q  <= bit_q + 5'd1;
                            if (bit_q == 5'd15) begin
                                copi_q  <= 1'b0;
                                state_q <= StHold;
                            end else begin
                                copi_q  <= shift_q[14];
                                shift_q <= {shift_q[14:0], 1'b0};
                            end
                        end else begin
                            sclk_q <= 1'b1;
`ifdef SPI_READ_EN
                            // Rising edges of bits 8..15 carry the response byte, MSB first.
                            if (bit_q >= 5'd8) begin
                                rx_q <= {rx_q[6:0], cipo};
                            end
`endif
                        end
                    end else begin
                        div_q <= div_q + DW'(1);
                    end
                end
                StHold: begin
                    if (div_q == DIV_LAST) begin
                        div_q   <= '0;
                        gap_q   <= '0;
                        ncs_q   <= 1'b1;
                        done_q  <= 1'b1;
`ifdef SPI_READ_EN
                        if (rd_q) begin
                            rsp_q <= rx_q;
                        end
`endif
                        state_q <= StGap;
                    end else begin
                        div_q <= div_q + DW'(1);
                    end
                end
                StGap: begin
                    if (gap_q == GAP_LAST) begin
                        ready_q <= 1'b1;
                        state_q <= StIdle;
                    end else begin
                        gap_q <= gap_q + GW'(1);
                    end
                end
                default: begin
                    state_q <= StIdle;
                    ncs_q   <= 1'b1;
                    sclk_q  <= 1'b0;
                    copi_q  <= 1'b0;
                    ready_q <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_spi_reg_writer.sv
// Self-checking bench for spi_reg_writer: SPI monitor, small register-peripheral model and
// optional cipo responder (SPI_READ_EN).
module tb_spi_reg_writer;

    localparam int unsigned CLK_DIV = 4;
    localparam int unsigned CS_GAP  = 4;
    localparam int LOW_CYC   = 33 * CLK_DIV;
    localparam int DONE_LAT  = 1 + 33 * CLK_DIV;
    localparam int READY_LAT = DONE_LAT + CS_GAP;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       req_valid;
    logic       req_ready;
    logic       req_write;
    logic [6:0] req_addr;
    logic [7:0] req_data;
    logic       done;
    logic [7:0] rsp_data;
    logic       sclk;
    logic       copi;
    logic       ncs;
    logic       cipo;

    spi_reg_writer #(
        .CLK_DIV(CLK_DIV),
        .CS_GAP (CS_GAP)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .req_write(req_write),
        .req_addr (req_addr),
        .req_data (req_data),
        .done     (done),
        .rsp_data (rsp_data),
        .sclk     (sclk),
        .copi     (copi),
        .ncs      (ncs),
        .cipo     (cipo)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Monitor + peripheral model: bits captured on sclk rise; a complete frame applies on ncs rise.
    logic [15:0] mon_shift = '0;
    int          mon_rises = 0;
    logic [15:0] mon_last = '0;
    int          mon_last_rises = 0;
    logic [7:0]  periph [0:4] = '{default: 8'h00};
    logic [7:0]  rsp_model = 8'h00;

    always @(posedge sclk or posedge ncs) begin
        if (ncs) begin
            if (mon_rises == 16 && mon_shift[15] && mon_shift[14:8] < 7'd5) begin
                periph[3'(mon_shift[14:8])] = mon_shift[7:0];
            end
            mon_last       = mon_shift;
            mon_last_rises = mon_rises;
            mon_shift      = '0;
            mon_rises      = 0;
        end else begin
            mon_shift = {mon_shift[14:0], copi};
            mon_rises = mon_rises + 1;
        end
    end

    always_comb begin
        cipo = 1'b0;
        if (mon_rises >= 8 && mon_rises < 16) begin
            cipo = rsp_model[3'(15 - mon_rises)];
        end
    end

    // Results of the most recent measured frame.
    logic [15:0] m_frame;
    int          m_rises;
    int          m_low;
    int          m_done_at;
    int          m_ready_at;
    int          m_bad_rdy;
    int          m_gap_high;
    logic [7:0]  m_rsp;
    logic [7:0]  exp_rsp = 8'h00;

    function automatic logic [15:0] model_frame(input logic wr, input logic [6:0] a,
                                                input logic [7:0] d);
`ifdef SPI_READ_EN
        return wr ? {1'b1, a, d} : {1'b0, a, 8'h00};
`else
        return {1'b1, a, d};
`endif
    endfunction

    // Entered at a negedge; returns just after the accepting posedge.
    task automatic wait_accept();
        for (int i = 0; i < 1000; i++) begin
            if (req_valid && req_ready) begin
                @(posedge clk);
                return;
            end
            @(negedge clk);
        end
        checks++;
        errors++;
        $display("FAIL accept_timeout: req_ready=%0b after 1000 cycles, required 1", req_ready);
    endtask

    task automatic start_req(input logic wr, input logic [6:0] a, input logic [7:0] d);
        @(negedge clk);
        req_valid = 1'b1;
        req_write = wr;
        req_addr  = a;
        req_data  = d;
        wait_accept();
        #1;
        req_valid = 1'b0;
        req_write = 1'($urandom);
        req_addr  = 7'($urandom);
        req_data  = 8'($urandom);
    endtask

    task automatic measure();
        m_frame    = '0;
        m_rises    = 0;
        m_low      = 0;
        m_done_at  = -1;
        m_ready_at = -1;
        m_bad_rdy  = 0;
        m_gap_high = 0;
        m_rsp      = '0;
        for (int cyc = 1; cyc <= 1000; cyc++) begin
            @(negedge clk);
            if (m_done_at < 0) begin
                if (!ncs) m_low++;
                if (req_ready) m_bad_rdy++;
                if (done) begin
                    m_done_at = cyc;
                    m_frame   = mon_last;
                    m_rises   = mon_last_rises;
                    m_rsp     = rsp_data;
                end
            end
            if (m_done_at >= 0) begin
                if (req_ready) begin
                    m_ready_at = cyc;
                    break;
                end
                if (ncs) m_gap_high++;
            end
        end
        if (m_ready_at < 0) begin
            checks++;
            errors++;
            $display("FAIL frame_timeout: done_at=%0d ready_at=%0d, required %0d/%0d",
                     m_done_at, m_ready_at, DONE_LAT, READY_LAT);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({ncs, sclk, copi, req_ready, done} !== 5'b10010) begin
            errors++;
            $display("FAIL reset_ctrl: {ncs,sclk,copi,ready,done}=%b required 10010",
                     {ncs, sclk, copi, req_ready, done});
        end
        checks++;
        if (rsp_data !== 8'h00) begin
            errors++;
            $display("FAIL reset_rsp: rsp_data=%h required 00", rsp_data);
        end
        rst_n = 1'b1;
        exp_rsp = 8'h00;
    endtask

    task automatic test_write_ff();
        start_req(1'b1, 7'h00, 8'hFF);
        measure();
        checks++;
        if (m_frame !== 16'h80FF) begin
            errors++;
            $display("FAIL wr_ff_frame: got %h required 80FF", m_frame);
        end
        checks++;
        if (m_rises != 16 || m_low != LOW_CYC) begin
            errors++;
            $display("FAIL wr_ff_shape: rises=%0d low=%0d required 16/%0d", m_rises, m_low, LOW_CYC);
        end
        checks++;
        if (m_done_at != DONE_LAT) begin
            errors++;
            $display("FAIL wr_ff_done: done at %0d required %0d", m_done_at, DONE_LAT);
        end
        checks++;
        if (periph[0] !== 8'hFF) begin
            errors++;
            $display("FAIL wr_ff_periph: reg0=%h required FF", periph[0]);
        end
    endtask

    task automatic test_ignore_busy();
        int starts;
        start_req(1'b1, 7'h03, 8'h5A);
        repeat (10) @(negedge clk);
        req_valid = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        measure();
        starts = 0;
        repeat (12) begin
            @(negedge clk);
            if (!ncs) starts++;
        end
        checks++;
        if (starts != 0) begin
            errors++;
            $display("FAIL busy_ignored: ncs low %0d cycles after idle, required 0", starts);
        end
    endtask

    task automatic test_back_to_back();
        @(negedge clk);
        req_valid = 1'b1;
        req_write = 1'b1;
        req_addr  = 7'h04;
        req_data  = 8'h80;
        wait_accept();
        #1;
        req_addr = 7'h02;
        req_data = 8'h01;
        measure();
        checks++;
        if (m_frame !== 16'h8480 || m_bad_rdy != 0) begin
            errors++;
            $display("FAIL b2b_first: frame %h ready_hi %0d required 8480/0", m_frame, m_bad_rdy);
        end
        checks++;
        if (m_gap_high < int'(CS_GAP) || m_ready_at != READY_LAT) begin
            errors++;
            $display("FAIL b2b_gap: gap %0d ready_at %0d required >=%0d/%0d",
                     m_gap_high, m_ready_at, CS_GAP, READY_LAT);
        end
        wait_accept();
        #1;
        req_valid = 1'b0;
        measure();
        checks++;
        if (m_frame !== 16'h8201 || m_bad_rdy != 0) begin
            errors++;
            $display("FAIL b2b_second: frame %h ready_hi %0d required 8201/0", m_frame, m_bad_rdy);
        end
    endtask

    task automatic test_reset_mid_frame();
        int pulses;
        bit reached;
        start_req(1'b1, 7'($urandom), 8'($urandom));
        reached = 1'b0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (mon_rises == 5) begin
                reached = 1'b1;
                break;
            end
        end
        checks++;
        if (!reached) begin
            errors++;
            $display("FAIL midrst_reach: rises=%0d required 5", mon_rises);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({ncs, sclk, copi, req_ready, done} !== 5'b10010 || rsp_data !== 8'h00) begin
            errors++;
            $display("FAIL midrst_async: {ncs,sclk,copi,ready,done}=%b rsp=%h required 10010/00",
                     {ncs, sclk, copi, req_ready, done}, rsp_data);
        end
        exp_rsp = 8'h00;
        pulses = 0;
        repeat (3) begin
            @(negedge clk);
            if (done) pulses++;
        end
        rst_n = 1'b1;
        repeat (5) begin
            @(negedge clk);
            if (done) pulses++;
        end
        checks++;
        if (pulses != 0) begin
            errors++;
            $display("FAIL midrst_done: %0d done pulses, required 0", pulses);
        end
        start_req(1'b1, 7'h01, 8'hAA);
        measure();
        checks++;
        if (m_frame !== 16'h81AA || m_done_at != DONE_LAT) begin
            errors++;
            $display("FAIL midrst_after: frame %h done %0d required 81AA/%0d",
                     m_frame, m_done_at, DONE_LAT);
        end
    endtask

    task automatic test_out_of_range();
        logic [7:0] snap [0:4];
        int diffs;
        snap = periph;
        start_req(1'b1, 7'h7F, 8'h12);
        measure();
        checks++;
        if (m_frame !== 16'hFF12) begin
            errors++;
            $display("FAIL oor_frame: got %h required FF12", m_frame);
        end
        diffs = 0;
        for (int i = 0; i < 5; i++) if (periph[i] !== snap[i]) diffs++;
        checks++;
        if (diffs != 0) begin
            errors++;
            $display("FAIL oor_periph: %0d registers changed, required 0", diffs);
        end
    endtask

`ifdef SPI_READ_EN
    task automatic test_read();
        rsp_model = 8'hA5;
        start_req(1'b0, 7'h04, 8'h3C);
        measure();
        exp_rsp = 8'hA5;
        checks++;
        if (m_frame !== 16'h0400 || m_rsp !== 8'hA5) begin
            errors++;
            $display("FAIL read_a5: frame %h rsp %h required 0400/A5", m_frame, m_rsp);
        end
    endtask
`endif

    task automatic test_random();
        logic        wr;
        logic [6:0]  a;
        logic [7:0]  d;
        logic [15:0] exp_frame;
        for (int n = 0; n < 8; n++) begin
            wr = 1'($urandom);
            a  = 7'($urandom);
            d  = 8'($urandom);
            rsp_model = 8'($urandom);
            exp_frame = model_frame(wr, a, d);
`ifdef SPI_READ_EN
            if (!wr) exp_rsp = rsp_model;
`endif
            start_req(wr, a, d);
            measure();
            checks++;
            if (m_frame !== exp_frame || m_rises != 16) begin
                errors++;
                $display("FAIL rnd_frame[%0d]: frame %h rises %0d required %h/16",
                         n, m_frame, m_rises, exp_frame);
            end
            checks++;
            if (m_low != LOW_CYC || m_done_at != DONE_LAT || m_ready_at != READY_LAT) begin
                errors++;
                $display("FAIL rnd_timing[%0d]: low %0d done %0d ready %0d required %0d/%0d/%0d",
                         n, m_low, m_done_at, m_ready_at, LOW_CYC, DONE_LAT, READY_LAT);
            end
            checks++;
            if (m_bad_rdy != 0 || m_gap_high != int'(CS_GAP)) begin
                errors++;
                $display("FAIL rnd_ready[%0d]: ready_hi %0d gap %0d required 0/%0d",
                         n, m_bad_rdy, m_gap_high, CS_GAP);
            end
            checks++;
            if (m_rsp !== exp_rsp) begin
                errors++;
                $display("FAIL rnd_rsp[%0d]: rsp %h required %h", n, m_rsp, exp_rsp);
            end
        end
    endtask

    initial begin
        rst_n     = 1'b0;
        req_valid = 1'b0;
        req_write = 1'b0;
        req_addr  = '0;
        req_data  = '0;
        test_reset();
        test_write_ff();
        test_ignore_busy();
        test_back_to_back();
        test_reset_mid_frame();
        test_out_of_range();
`ifdef SPI_READ_EN
        test_read();
`endif
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation exceeded 2 ms");
        $fatal(1);
    end

endmodule
